// File: rtl/zx81_p_loader.sv
// Purpose : streams a .P program file from the HPS download channel into main
//           RAM port B starting at BASE_ADDR, holding the CPU while loading and
//           capturing the file's E_LINE system variable (file bytes 0x0B/0x0C).
// Ports   : clock, reset_n (sync, active-low); download side dl_active, dl_wr,
//           dl_data, dl_wait; RAM port B ram_we, ram_addr, ram_data; status
//           cpu_hold, done, error, byte_count, e_line. All outputs registered.
module zx81_p_loader #(
  parameter int                   ADDRWIDTH = 14,
  parameter int                   NUMWORDS  = 16384,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = 14'h0009
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 dl_active,
  input  logic                 dl_wr,
  input  logic [7:0]           dl_data,
  output logic                 dl_wait,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          byte_count,
  output logic [15:0]          e_line
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

  localparam logic [16:0] LIMIT  = 17'(NUMWORDS);
  localparam logic [16:0] BASE17 = 17'(BASE_ADDR);

  state_t state, state_nxt;
  logic   dl_active_q;
  logic   rise;

  // Overflow test uses the unwrapped 17-bit target address.
  logic [16:0] wr_sum;

  logic                 dl_wait_nxt;
  logic                 ram_we_nxt;
  logic [ADDRWIDTH-1:0] ram_addr_nxt;
  logic [7:0]           ram_data_nxt;
  logic                 cpu_hold_nxt;
  logic                 done_nxt;
  logic                 error_nxt;
  logic [15:0]          byte_count_nxt;
  logic [15:0]          e_line_nxt;

  assign rise   = dl_active & ~dl_active_q;
  assign wr_sum = BASE17 + {1'b0, byte_count};

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = LOAD;
      LOAD: begin
        if (dl_wr)           state_nxt = WRITE;
        else if (!dl_active) state_nxt = FINISH;
      end
      WRITE:   state_nxt = LOAD;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    dl_wait_nxt    = dl_wait;
    ram_we_nxt     = 1'b0;
    ram_addr_nxt   = ram_addr;
    ram_data_nxt   = ram_data;
    cpu_hold_nxt   = cpu_hold;
    done_nxt       = 1'b0;
    error_nxt      = error;
    byte_count_nxt = byte_count;
    e_line_nxt     = e_line;
    case (state)
      IDLE: begin
        dl_wait_nxt = 1'b0;
        if (rise) begin
          byte_count_nxt = 16'h0000;
          e_line_nxt     = 16'h0000;
          error_nxt      = 1'b0;
          cpu_hold_nxt   = 1'b1;
        end
      end
      LOAD: begin
        if (dl_wr) begin
          ram_data_nxt = dl_data;
          ram_addr_nxt = BASE_ADDR + byte_count[ADDRWIDTH-1:0];
          dl_wait_nxt  = 1'b1;
        end else begin
          dl_wait_nxt  = 1'b0;
        end
      end
      WRITE: begin
        // dl_wait stays up through the commit cycle that follows; LOAD drops
        // it unless a new byte arrives right away.
        dl_wait_nxt = 1'b1;
        if (wr_sum >= LIMIT) error_nxt  = 1'b1;
        else                 ram_we_nxt = 1'b1;
        if (byte_count == 16'h000B) e_line_nxt[7:0]  = ram_data;
        if (byte_count == 16'h000C) e_line_nxt[15:8] = ram_data;
        if (byte_count != 16'hFFFF) byte_count_nxt = byte_count + 16'h0001;
        // A strobe while a byte is still in flight is dropped.
        if (dl_wr) error_nxt = 1'b1;
      end
      FINISH: begin
        done_nxt     = 1'b1;
        cpu_hold_nxt = 1'b0;
        dl_wait_nxt  = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dl_active_q <= 1'b0;
      dl_wait     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= 8'h00;
      cpu_hold    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      byte_count  <= 16'h0000;
      e_line      <= 16'h0000;
    end else begin
      dl_active_q <= dl_active;
      dl_wait     <= dl_wait_nxt;
      ram_we      <= ram_we_nxt;
      ram_addr    <= ram_addr_nxt;
      ram_data    <= ram_data_nxt;
      cpu_hold    <= cpu_hold_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      byte_count  <= byte_count_nxt;
      e_line      <= e_line_nxt;
    end
  end

endmodule

// File: tb/tb_zx81_p_loader.sv
module tb_zx81_p_loader;

  localparam int AW   = 14;
  localparam int NW   = 1024;
  localparam int BASE = 9;

  logic          clock;
  logic          reset_n;
  logic          dl_active;
  logic          dl_wr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [15:0]   byte_count;
  logic [15:0]   e_line;

  zx81_p_loader #(
    .ADDRWIDTH (AW),
    .NUMWORDS  (NW),
    .BASE_ADDR (14'h0009)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .byte_count (byte_count),
    .e_line     (e_line)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // RAM image as seen through port B; -1 marks a word never written.
  int tb_mem [16384];
  int we_cnt;
  int done_cnt;
  int oob_cnt;
  int last_addr;

  logic [7:0] bytes_q [$];

  always @(negedge clock) begin
    if (ram_we === 1'b1) begin
      tb_mem[ram_addr] = int'(ram_data);
      we_cnt++;
      last_addr = int'(ram_addr);
      if (int'(ram_addr) >= NW) oob_cnt++;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16384; i++) tb_mem[i] = -1;
    we_cnt    = 0;
    oob_cnt   = 0;
    last_addr = -1;
  endtask

  task automatic start_load();
    clear_mem();
    done_cnt  = 0;
    dl_active = 1'b1;
    tick();
    check("hold_on", cpu_hold, 1);
    check("err_clr", error, 0);
    check("bc_clr", byte_count, 0);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check(tag, (t < 40), 1);
    check("hold_off", cpu_hold, 0);
    tick();
    tick();
    tick();
  endtask

  task automatic send_bytes(input int gap);
    foreach (bytes_q[i]) begin
      dl_wr   = 1'b1;
      dl_data = bytes_q[i];
      tick();
      dl_wr = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic do_load(input int gap);
    start_load();
    send_bytes(gap);
    tick();
    dl_active = 1'b0;
    wait_done("done_seen");
  endtask

  // Reference: byte i belongs at word BASE+i unless that is past the RAM end.
  task automatic check_load(input string tag);
    int n;
    int exp_we;
    logic [15:0] exp_el;
    n      = bytes_q.size();
    exp_we = 0;
    exp_el = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (BASE + i < NW) begin
        exp_we++;
        check({tag, "_mem"}, tb_mem[BASE + i], int'(bytes_q[i]));
      end
    end
    if (n > 11) exp_el[7:0]  = bytes_q[11];
    if (n > 12) exp_el[15:8] = bytes_q[12];
    check({tag, "_we"},    we_cnt, exp_we);
    check({tag, "_bc"},    byte_count, (n > 65535) ? 65535 : n);
    check({tag, "_eline"}, e_line, exp_el);
    check({tag, "_err"},   error, (BASE + n > NW) ? 1 : 0);
    check({tag, "_done"},  done_cnt, 1);
    check({tag, "_oob"},   oob_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int g;
    int dc;

    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_data   = 8'h00;
    clear_mem();
    done_cnt = 0;
    repeat (3) tick();
    check("rst_outs", {dl_wait, ram_we, cpu_hold, done, error}, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_bc", byte_count, 0);
    check("rst_eline", e_line, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Strobes with no download in progress are ignored.
    dl_wr = 1'b1; dl_data = 8'h77;
    tick();
    dl_wr = 1'b0;
    repeat (3) tick();
    check("idle_wr_we", we_cnt, 0);
    check("idle_wr_err", error, 0);
    check("idle_wr_hold", cpu_hold, 0);

    // Basic load: 0x20 bytes, value = index.
    bytes_q.delete();
    for (int i = 0; i < 32; i++) bytes_q.push_back(8'(i));
    do_load(2);
    check_load("basic");
    check("basic_eline_k", e_line, 16'h0C0B);

    // Randomized loads.
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 40);
      g = $urandom_range(2, 4);
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
      do_load(g);
      check_load("rand");
    end

    // Overflow: 1020 bytes into a 1024-word RAM.
    bytes_q.delete();
    for (int i = 0; i < 1020; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    do_load(2);
    check_load("ovf");
    check("ovf_last", last_addr, 32'h3FF);

    // Back-to-back strobes: second one is a violation.
    start_load();
    dl_wr = 1'b1; dl_data = 8'hAA;
    tick();
    dl_data = 8'h55;
    tick();
    dl_wr = 1'b0;
    tick();
    tick();
    dl_active = 1'b0;
    wait_done("viol_done");
    check("viol_mem9", tb_mem[9], 32'hAA);
    check("viol_mem10", tb_mem[10], -1);
    check("viol_we", we_cnt, 1);
    check("viol_err", error, 1);
    check("viol_bc", byte_count, 1);

    // Early end: dl_active drops as the 3rd byte enters WRITE.
    start_load();
    bytes_q.delete();
    bytes_q.push_back(8'h10);
    bytes_q.push_back(8'h11);
    send_bytes(2);
    dl_wr = 1'b1; dl_data = 8'h12;
    tick();
    dl_wr     = 1'b0;
    dl_active = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("early_lat", n, 3);
    check("early_hold", cpu_hold, 0);
    tick();
    tick();
    check("early_mem", tb_mem[11], 32'h12);
    check("early_bc", byte_count, 3);
    check("early_err", error, 0);

    // Reset in the middle of a load.
    bytes_q.delete();
    for (int i = 0; i < 5; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    start_load();
    send_bytes(2);
    dc = done_cnt;
    reset_n   = 1'b0;
    dl_active = 1'b0;
    tick();
    check("mrst_hold", cpu_hold, 0);
    check("mrst_bc", byte_count, 0);
    check("mrst_wait", dl_wait, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("mrst_nodone", done_cnt, dc);

    n = $urandom_range(1, 20);
    bytes_q.delete();
    for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    do_load(3);
    check_load("fresh");
    check("fresh_first", tb_mem[9], int'(bytes_q[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
